pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/adder_pkg.sv | 20 ++
 rtl/pipe_adder_if.sv | 41 ++++
 rtl/adder_slice.sv | 16 +
 rtl/pipe_adder.sv | 118 +++++++++++
 tb/tb_pipe_adder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants, per-stage record and helpers for the pipelined adder.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH  = 32;
  localparam int unsigned ADDER_STAGES = 4;
  // Widest slice a stage record can hold; narrower slices occupy the low bits.
  localparam int unsigned ADDER_SLICE_MAX_W = 64;

  typedef struct packed {
    logic                         valid;
    logic                         carry;
    logic [ADDER_SLICE_MAX_W-1:0] slice;
  } stage_t;

  // Two's-complement overflow from the sign bits of both addends and the result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; ovf exists only with ADDER_OVF_EN.
interface pipe_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif

endinterface

// File: rtl/adder_slice.sv
// Combinational SLICE_W-bit ripple slice: one pipeline stage's worth of addition.
module adder_slice #(
  parameter int unsigned SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int unsigned EXT_W = SLICE_W + 1;

  assign {cout, sum} = EXT_W'(a) + EXT_W'(b) + EXT_W'(cin);

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined adder: one WIDTH/STAGES slice per stage, operands skewed in, results deskewed out.
// Define ADDER_OVF_EN to add the registered signed-overflow output.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADDER_WIDTH,
  parameter int unsigned STAGES = ADDER_STAGES
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_if.slave bus
);

  localparam int unsigned SW    = WIDTH / STAGES;
  localparam int unsigned DLY_N = (STAGES > 1) ? STAGES - 1 : 1;

  stage_t          st_q  [STAGES];
  logic [SW-1:0]   ska_q [STAGES][DLY_N];
  logic [SW-1:0]   skb_q [STAGES][DLY_N];
  logic [SW-1:0]   rd_q  [STAGES][DLY_N];

  logic [SW-1:0]   op_a     [STAGES];
  logic [SW-1:0]   op_b     [STAGES];
  logic            carry_in [STAGES];
  logic [SW-1:0]   s_c      [STAGES];
  logic            co_c     [STAGES];
  logic [SW-1:0]   res      [STAGES];
  logic [WIDTH-1:0] sum_c;
  logic            advance;

  // The whole pipe moves together; a held result freezes every stage behind it.
  assign advance      = !st_q[STAGES-1].valid || bus.out_ready;
  assign bus.in_ready = !rst && advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign op_a[k]     = bus.a[SW-1:0];
      assign op_b[k]     = bus.b[SW-1:0];
      assign carry_in[k] = bus.cin;
    end else begin : g_body
      assign op_a[k]     = ska_q[k][k-1];
      assign op_b[k]     = skb_q[k][k-1];
      assign carry_in[k] = st_q[k-1].carry;
    end

    adder_slice #(.SLICE_W(SW)) u_slice (
      .a    (op_a[k]),
      .b    (op_b[k]),
      .cin  (carry_in[k]),
      .sum  (s_c[k]),
      .cout (co_c[k])
    );

    if (k < STAGES - 1) begin : g_align
      assign res[k] = rd_q[k][STAGES-2-k];
    end else begin : g_last
      assign res[k] = SW'(st_q[k].slice);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum_c[k*SW +: SW] = res[k];
    end
  end

  // Stage records, operand skew chains and result alignment chains.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
        for (int j = 0; j < DLY_N; j++) begin
          ska_q[k][j] <= '0;
          skb_q[k][j] <= '0;
          rd_q[k][j]  <= '0;
        end
      end
    end else if (advance) begin
      st_q[0] <= '{valid: bus.in_valid, carry: co_c[0], slice: ADDER_SLICE_MAX_W'(s_c[0])};
      for (int k = 1; k < STAGES; k++) begin
        st_q[k]     <= '{valid: st_q[k-1].valid, carry: co_c[k], slice: ADDER_SLICE_MAX_W'(s_c[k])};
        ska_q[k][0] <= bus.a[k*SW +: SW];
        skb_q[k][0] <= bus.b[k*SW +: SW];
        for (int j = 1; j < k; j++) begin
          ska_q[k][j] <= ska_q[k][j-1];
          skb_q[k][j] <= skb_q[k][j-1];
        end
      end
      for (int k = 0; k + 1 < STAGES; k++) begin
        rd_q[k][0] <= SW'(st_q[k].slice);
        for (int j = 1; j + k + 1 < STAGES; j++) begin
          rd_q[k][j] <= rd_q[k][j-1];
        end
      end
    end
  end

`ifdef ADDER_OVF_EN
  logic ovf_q;

  // Sign bits of the top slice reach the last stage together with its sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= signed_ovf(op_a[STAGES-1][SW-1], op_b[STAGES-1][SW-1], s_c[STAGES-1][SW-1]);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.out_valid = st_q[STAGES-1].valid;
  assign bus.cout      = st_q[STAGES-1].carry;
  assign bus.sum       = sum_c;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed steps on an 8-bit/2-stage instance, random traffic on 32-bit/4-stage.
module tb_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(8))  bus_s ();
  pipe_adder_if #(.WIDTH(32)) bus_l ();

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_small (.clk(clk), .rst(rst), .bus(bus_s));
  pipe_adder #(.WIDTH(32), .STAGES(4)) u_large (.clk(clk), .rst(rst), .bus(bus_l));

  logic [32:0] q_res [$];
  logic        q_ovf [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return 9'(t);
  endfunction

  function automatic logic [32:0] ref_add32(input logic [31:0] a, input logic [31:0] b, input logic c);
    longint unsigned t;
    t = longint'(a) + longint'(b) + longint'(c);
    return 33'(t);
  endfunction

  function automatic logic ref_ovf(input longint sa, input longint sb, input logic c, input int w);
    longint t;
    longint lim;
    t   = sa + sb + longint'(c);
    lim = longint'(1) << (w - 1);
    return (t >= lim) || (t < -lim);
  endfunction

  task automatic drive_s(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic rdy);
    bus_s.in_valid  = v;
    bus_s.a         = a;
    bus_s.b         = b;
    bus_s.cin       = c;
    bus_s.out_ready = rdy;
  endtask

  // Compare the small instance's output beat against the arithmetic result of (a, b, c).
  task automatic chk_s(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] e;
    e = ref_add8(a, b, c);
    chk({tag, ".valid"}, 64'(bus_s.out_valid), 64'(1));
    chk({tag, ".sum"},   64'(bus_s.sum),       64'(e[7:0]));
    chk({tag, ".cout"},  64'(bus_s.cout),      64'(e[8]));
`ifdef ADDER_OVF_EN
    chk({tag, ".ovf"}, 64'(bus_s.ovf),
        64'(ref_ovf(longint'($signed(a)), longint'($signed(b)), c, 8)));
`endif
  endtask

  initial begin
    int unsigned sent;
    int          cyc;
    logic        stall;
    logic [31:0] hold_sum;
    logic        hold_cout;
    logic [32:0] e;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;

    rst = 1'b1;
    drive_s(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    bus_l.in_valid  = 1'b0;
    bus_l.a         = '0;
    bus_l.b         = '0;
    bus_l.cin       = 1'b0;
    bus_l.out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst.in_ready",  64'(bus_s.in_ready),  64'(0));
    chk("rst.out_valid", 64'(bus_s.out_valid), 64'(0));
    chk("rst.sum",       64'(bus_s.sum),       64'(0));
    chk("rst.cout",      64'(bus_s.cout),      64'(0));
    rst = 1'b0;
    #1;
    chk("rel.in_ready",  64'(bus_s.in_ready),  64'(1));

    // Single beat latency
    drive_s(1'b1, 8'h0F, 8'h01, 1'b0, 1'b1);
    step();
    drive_s(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("lat.early", 64'(bus_s.out_valid), 64'(0));
    step();
    chk_s("lat", 8'h0F, 8'h01, 1'b0);
    step();
    chk("lat.drain", 64'(bus_s.out_valid), 64'(0));

    // Carry wrap, then sign overflow pattern
    drive_s(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
    step();
    drive_s(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
    step();
    drive_s(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk_s("wrap", 8'hFF, 8'h00, 1'b1);
    step();
    chk_s("sgn", 8'h7F, 8'h01, 1'b0);

    // Back-to-back beats
    drive_s(1'b1, 8'h01, 8'h01, 1'b0, 1'b1);
    step();
    drive_s(1'b1, 8'h02, 8'h02, 1'b0, 1'b1);
    step();
    chk_s("b2b0", 8'h01, 8'h01, 1'b0);
    drive_s(1'b1, 8'h03, 8'h03, 1'b0, 1'b1);
    step();
    chk_s("b2b1", 8'h02, 8'h02, 1'b0);
    drive_s(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    step();
    chk_s("b2b2", 8'h03, 8'h03, 1'b0);
    step();
    chk("b2b.drain", 64'(bus_s.out_valid), 64'(0));

    // Stall with a result pending and a beat waiting at the input
    drive_s(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    step();
    drive_s(1'b1, 8'h30, 8'h40, 1'b1, 1'b0);
    step();
    drive_s(1'b1, 8'h55, 8'hAA, 1'b1, 1'b0);
    #1;
    chk("stall.in_ready", 64'(bus_s.in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk_s("stall.hold", 8'h10, 8'h20, 1'b0);
      chk("stall.in_ready_h", 64'(bus_s.in_ready), 64'(0));
    end
    bus_s.out_ready = 1'b1;
    #1;
    chk("resume.in_ready", 64'(bus_s.in_ready), 64'(1));
    step();
    drive_s(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk_s("resume.b", 8'h30, 8'h40, 1'b1);
    step();
    chk_s("resume.c", 8'h55, 8'hAA, 1'b1);
    step();
    chk("resume.drain", 64'(bus_s.out_valid), 64'(0));

    // Reset with two beats in flight
    drive_s(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
    step();
    drive_s(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
    step();
    chk_s("prerst", 8'h11, 8'h22, 1'b0);
    drive_s(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst.out_valid", 64'(bus_s.out_valid), 64'(0));
    chk("midrst.sum",       64'(bus_s.sum),       64'(0));
    chk("midrst.cout",      64'(bus_s.cout),      64'(0));
    chk("midrst.in_ready",  64'(bus_s.in_ready),  64'(0));
    rst = 1'b0;
    bus_s.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst.stale", 64'(bus_s.out_valid), 64'(0));
    end

    // Random traffic on the wide instance against an in-order queue model
    sent  = 0;
    cyc   = 0;
    stall = 1'b0;
    while ((sent < 10000 || q_res.size() > 0) && cyc < 60000) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      bus_l.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      bus_l.a         = ra;
      bus_l.b         = rb;
      bus_l.cin       = rc;
      bus_l.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus_l.out_valid && bus_l.out_ready) begin
        if (q_res.size() == 0) begin
          chk("rnd.extra", 64'(bus_l.out_valid), 64'(0));
        end else begin
          e = q_res.pop_front();
          chk("rnd.sum",  64'(bus_l.sum),  64'(e[31:0]));
          chk("rnd.cout", 64'(bus_l.cout), 64'(e[32]));
`ifdef ADDER_OVF_EN
          chk("rnd.ovf", 64'(bus_l.ovf), 64'(q_ovf.pop_front()));
`endif
        end
      end
      if (bus_l.in_valid && bus_l.in_ready) begin
        q_res.push_back(ref_add32(ra, rb, rc));
        q_ovf.push_back(ref_ovf(longint'($signed(ra)), longint'($signed(rb)), rc, 32));
        sent++;
      end
      stall     = bus_l.out_valid && !bus_l.out_ready;
      hold_sum  = bus_l.sum;
      hold_cout = bus_l.cout;
      step();
      cyc++;
      if (stall) begin
        chk("rnd.hold_valid", 64'(bus_l.out_valid), 64'(1));
        chk("rnd.hold_sum",   64'(bus_l.sum),       64'(hold_sum));
        chk("rnd.hold_cout",  64'(bus_l.cout),      64'(hold_cout));
      end
    end
    bus_l.in_valid = 1'b0;
    chk("rnd.sent",  64'(sent),          64'(10000));
    chk("rnd.drain", 64'(q_res.size()),  64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
